dmem_arbiter: RTL and testbench

//  Shares the single data-memory port (memoryunit) between the core load/store path (CPU) and a debug/loader port (DBG).

---
 rtl/dmem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core load/store path (CPU) and a
// debug/loader port (DBG); each access runs IDLE -> BUSY (MEM_LATENCY cycles) -> RESP.
module dmem_arbiter #(
    parameter int unsigned BITNESS      = 32,
    parameter int unsigned ADDR_WIDTH   = 17,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [BITNESS-1:0]    cpu_addr_i,
    input  logic [BITNESS-1:0]    cpu_wdata_i,
    input  logic [2:0]            cpu_funct3_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_rvalid_o,
    output logic [BITNESS-1:0]    cpu_rdata_o,

    input  logic                  dbg_req_i,
    input  logic                  dbg_we_i,
    input  logic [BITNESS-1:0]    dbg_addr_i,
    input  logic [BITNESS-1:0]    dbg_wdata_i,
    input  logic [2:0]            dbg_funct3_i,
    output logic                  dbg_gnt_o,
    output logic                  dbg_rvalid_o,
    output logic [BITNESS-1:0]    dbg_rdata_o,

    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [BITNESS-1:0]    mem_wdata_o,
    output logic [2:0]            mem_funct3_o,
    output logic                  mem_we_o,
    output logic                  mem_re_o,
    input  logic [BITNESS-1:0]    mem_rdata_i,

    output logic                  stall_o
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [STV_W-1:0]      starve_q, starve_d;
    logic [CNT_W-1:0]      busy_cnt_q, busy_cnt_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BITNESS-1:0]    wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [BITNESS-1:0]    rdata_q, rdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_re_q, mem_re_d;
    logic                  cpu_gnt_q, cpu_gnt_d;
    logic                  dbg_gnt_q, dbg_gnt_d;
    logic                  cpu_rvalid_q, cpu_rvalid_d;
    logic                  dbg_rvalid_q, dbg_rvalid_d;
    logic [BITNESS-1:0]    cpu_rdata_q, cpu_rdata_d;
    logic [BITNESS-1:0]    dbg_rdata_q, dbg_rdata_d;

    logic                  dbg_wins;
    logic                  sel_we;
    logic [BITNESS-1:0]    sel_addr;
    logic                  sel_oor;

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            starve_q     <= '0;
            busy_cnt_q   <= '0;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            rdata_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dbg_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            busy_cnt_q   <= busy_cnt_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            rdata_q      <= rdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            cpu_gnt_q    <= cpu_gnt_d;
            dbg_gnt_q    <= dbg_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Arbitration, access sequencing and response generation
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        busy_cnt_d   = busy_cnt_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        rdata_d      = rdata_q;
        mem_we_d     = 1'b0;
        mem_re_d     = mem_re_q;
        cpu_gnt_d    = 1'b0;
        dbg_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        cpu_rdata_d  = '0;
        dbg_rdata_d  = '0;

        dbg_wins = dbg_req_i & (~cpu_req_i | (starve_q == STV_W'(STARVE_LIMIT)));
        sel_we   = dbg_wins ? dbg_we_i   : cpu_we_i;
        sel_addr = dbg_wins ? dbg_addr_i : cpu_addr_i;
        sel_oor  = |sel_addr[BITNESS-1:ADDR_WIDTH];

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req_i || dbg_req_i) begin
                    state_d    = ST_BUSY;
                    busy_cnt_d = '0;
                    owner_d    = dbg_wins;
                    addr_d     = sel_addr[ADDR_WIDTH-1:0];
                    wdata_d    = dbg_wins ? dbg_wdata_i  : cpu_wdata_i;
                    funct3_d   = dbg_wins ? dbg_funct3_i : cpu_funct3_i;
                    rdata_d    = '0;
                    cpu_gnt_d  = ~dbg_wins;
                    dbg_gnt_d  = dbg_wins;
                    // Out-of-range accesses complete normally but never touch memory
                    mem_we_d   = sel_we & ~sel_oor;
                    mem_re_d   = ~sel_we & ~sel_oor;
                    if (dbg_wins) begin
                        starve_d = '0;
                    end else if (dbg_req_i && (starve_q != STV_W'(STARVE_LIMIT))) begin
                        starve_d = starve_q + STV_W'(1);
                    end
                end
            end
            ST_BUSY: begin
                if (busy_cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
                    rdata_d  = mem_re_q ? mem_rdata_i : '0;
                    mem_re_d = 1'b0;
                    state_d  = ST_RESP;
                end else begin
                    busy_cnt_d = busy_cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                cpu_rvalid_d = ~owner_q;
                dbg_rvalid_d = owner_q;
                cpu_rdata_d  = owner_q ? '0 : rdata_q;
                dbg_rdata_d  = owner_q ? rdata_q : '0;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_re_d = 1'b0;
            end
        endcase
    end

    assign cpu_gnt_o    = cpu_gnt_q;
    assign dbg_gnt_o    = dbg_gnt_q;
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign dbg_rvalid_o = dbg_rvalid_q;
    assign cpu_rdata_o  = cpu_rdata_q;
    assign dbg_rdata_o  = dbg_rdata_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_funct3_o = funct3_q;
    assign mem_we_o     = mem_we_q;
    assign mem_re_o     = mem_re_q;

    // Holds the core until its access completes; drops for exactly the rvalid cycle
    assign stall_o = cpu_req_i & ~cpu_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MEM_LATENCY 1 and 3) checked every cycle
// against a timeline model of each access (grant, memory strobes, response).
module tb_dmem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [2];
    logic        req    [2][2];
    logic        we     [2][2];
    logic [31:0] addr   [2][2];
    logic [31:0] wdata  [2][2];
    logic [2:0]  f3     [2][2];
    logic        gnt    [2][2];
    logic        rvalid [2][2];
    logic [31:0] rdata  [2][2];
    logic [16:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [2:0]  mem_f3    [2];
    logic        mem_we    [2];
    logic        mem_re    [2];
    logic [31:0] mem_rdata [2];
    logic        stall     [2];

    function automatic logic [31:0] rom(input logic [16:0] a);
        if (a == 17'h00010) return 32'hDEADBEEF;
        return {a[14:0], a} ^ 32'h5A3C_96E1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter #(
            .BITNESS(32), .ADDR_WIDTH(17),
            .MEM_LATENCY((g == 0) ? 1 : 3), .STARVE_LIMIT(LIMIT)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n[g]),
            .cpu_req_i(req[g][0]), .cpu_we_i(we[g][0]), .cpu_addr_i(addr[g][0]),
            .cpu_wdata_i(wdata[g][0]), .cpu_funct3_i(f3[g][0]),
            .cpu_gnt_o(gnt[g][0]), .cpu_rvalid_o(rvalid[g][0]), .cpu_rdata_o(rdata[g][0]),
            .dbg_req_i(req[g][1]), .dbg_we_i(we[g][1]), .dbg_addr_i(addr[g][1]),
            .dbg_wdata_i(wdata[g][1]), .dbg_funct3_i(f3[g][1]),
            .dbg_gnt_o(gnt[g][1]), .dbg_rvalid_o(rvalid[g][1]), .dbg_rdata_o(rdata[g][1]),
            .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]), .mem_funct3_o(mem_f3[g]),
            .mem_we_o(mem_we[g]), .mem_re_o(mem_re[g]), .mem_rdata_i(mem_rdata[g]),
            .stall_o(stall[g])
        );
        assign mem_rdata[g] = rom(mem_addr[g]);
    end

    // Reference model: one record per instance describing the access in flight
    bit          mdl_act    [2];
    int          mdl_start  [2];
    int          mdl_own    [2];
    bit          mdl_we     [2];
    logic [31:0] mdl_addr   [2];
    logic [31:0] mdl_wdata  [2];
    logic [2:0]  mdl_f3     [2];
    int          mdl_starve [2];

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int n_wr [2];
    int gq [$];

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int age(input int k);
        return cyc - mdl_start[k];
    endfunction

    function automatic bit exp_gnt(input int k, input int p);
        return mdl_act[k] && age(k) == 1 && mdl_own[k] == p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        #1;
        for (int k = 0; k < 2; k++) begin
            int  d;
            bit  rsp, in_rng, ewe, ere;
            d      = age(k);
            rsp    = mdl_act[k] && d == lat(k) + 2;
            in_rng = (mdl_addr[k][31:17] == 15'd0);
            ewe    = mdl_act[k] && d == 1 && mdl_we[k] && in_rng;
            ere    = mdl_act[k] && d >= 1 && d <= lat(k) && !mdl_we[k] && in_rng;
            if (cyc > 0) begin
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("gnt[%0d][%0d]", k, p), 32'(gnt[k][p]), 32'(exp_gnt(k, p)));
                    chk($sformatf("rvalid[%0d][%0d]", k, p), 32'(rvalid[k][p]),
                        32'(rsp && mdl_own[k] == p));
                    if (rsp)
                        chk($sformatf("rdata[%0d][%0d]", k, p), rdata[k][p],
                            (mdl_own[k] == p && !mdl_we[k] && in_rng) ? rom(mdl_addr[k][16:0]) : 32'h0);
                end
                chk($sformatf("mem_we[%0d]", k), 32'(mem_we[k]), 32'(ewe));
                chk($sformatf("mem_re[%0d]", k), 32'(mem_re[k]), 32'(ere));
                if (ewe || ere) begin
                    chk($sformatf("mem_addr[%0d]", k), 32'(mem_addr[k]), 32'(mdl_addr[k][16:0]));
                    chk($sformatf("mem_funct3[%0d]", k), 32'(mem_f3[k]), 32'(mdl_f3[k]));
                end
                if (ewe) chk($sformatf("mem_wdata[%0d]", k), mem_wdata[k], mdl_wdata[k]);
                chk($sformatf("stall[%0d]", k), 32'(stall[k]),
                    32'(req[k][0] && !(rsp && mdl_own[k] == 0)));
                if (mem_we[k] === 1'b1) n_wr[k]++;
                if (k == 0 && gnt[0][0] === 1'b1) gq.push_back(0);
                if (k == 0 && gnt[0][1] === 1'b1) gq.push_back(1);
            end
            // Advance the model across the clock edge that ends this cycle
            if (!rst_n[k]) begin
                mdl_act[k]    = 0;
                mdl_starve[k] = 0;
            end else if (!mdl_act[k] || d >= lat(k) + 2) begin
                if (req[k][0] || req[k][1]) begin
                    int w;
                    w = (req[k][1] && (!req[k][0] || mdl_starve[k] == int'(LIMIT))) ? 1 : 0;
                    if (w == 1) mdl_starve[k] = 0;
                    else if (req[k][1] && mdl_starve[k] < int'(LIMIT)) mdl_starve[k]++;
                    mdl_own[k]   = w;
                    mdl_we[k]    = we[k][w];
                    mdl_addr[k]  = addr[k][w];
                    mdl_wdata[k] = wdata[k][w];
                    mdl_f3[k]    = f3[k][w];
                    mdl_start[k] = cyc;
                    mdl_act[k]   = 1;
                end else begin
                    mdl_act[k] = 0;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic rand_fields(input int k, input int p);
        we[k][p]    = 1'($urandom_range(0, 1));
        addr[k][p]  = $urandom() & 32'h0001_FFFF;
        if ($urandom_range(0, 7) == 0) addr[k][p] |= 32'h1 << $urandom_range(17, 31);
        wdata[k][p] = $urandom();
        f3[k][p]    = 3'($urandom_range(0, 7));
    endtask

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            req[k][0] = 1'b0;
            req[k][1] = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            if (!mdl_act[0] && !mdl_act[1]) return;
            step();
        end
        chk("idle_timeout", 32'(mdl_act[0] || mdl_act[1]), 32'h0);
    endtask

    task automatic setup(input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f);
        for (int k = 0; k < 2; k++) begin
            req[k][p] = 1'b1; we[k][p] = w; addr[k][p] = a; wdata[k][p] = wd; f3[k][p] = f;
        end
    endtask

    task automatic access(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f);
        setup(p, w, a, wd, f);
        step();
        idle_all();
    endtask

    initial begin
        int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int k = 0; k < 2; k++) begin
            n_wr[k] = 0;
            mdl_act[k] = 0; mdl_start[k] = 0; mdl_own[k] = 0; mdl_we[k] = 0;
            mdl_addr[k] = '0; mdl_wdata[k] = '0; mdl_f3[k] = '0; mdl_starve[k] = 0;
            for (int p = 0; p < 2; p++) rand_fields(k, p);
        end

        // Reset held with both requesters asserting
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req[k][0] = 1'b1; req[k][1] = 1'b1; we[k][0] = 1'b1; we[k][1] = 1'b1;
        end
        repeat (3) step();
        chk("reset_writes0", 32'(n_wr[0]), 32'h0);
        chk("reset_writes1", 32'(n_wr[1]), 32'h0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        idle_all();

        // Load with known data, then a store
        access(0, 1'b0, 32'h0000_0010, 32'h0, 3'b010);
        n_wr[0] = 0; n_wr[1] = 0;
        access(0, 1'b1, 32'h0000_0020, 32'h1234_5678, 3'b010);
        chk("store_writes0", 32'(n_wr[0]), 32'h1);
        chk("store_writes1", 32'(n_wr[1]), 32'h1);

        // Both ports requesting continuously: starvation limit forces DBG through
        gq.delete();
        setup(0, 1'b0, 32'h0000_0100, 32'h0, 3'b010);
        setup(1, 1'b0, 32'h0000_0200, 32'h0, 3'b010);
        for (int i = 0; i < 200 && gq.size() < 10; i++) step();
        chk("grant_count", 32'(gq.size() >= 10), 32'h1);
        for (int i = 0; i < 10 && i < gq.size(); i++)
            chk($sformatf("grant_order%0d", i), 32'(gq[i]), 32'(exp_seq[i]));
        idle_all();

        // Out-of-range load
        access(0, 1'b0, 32'h0002_0000, 32'h0, 3'b010);
        access(1, 1'b0, 32'h8000_0044, 32'h0, 3'b100);

        // Reset in the middle of a store, then a normal access
        n_wr[0] = 0; n_wr[1] = 0;
        setup(0, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 3'b010);
        step();
        req[0][0] = 1'b0; req[1][0] = 1'b0;
        step();
        rst_n[0] = 1'b0; rst_n[1] = 1'b0;
        step();
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        idle_all();
        chk("abort_writes0", 32'(n_wr[0]), 32'h1);
        chk("abort_writes1", 32'(n_wr[1]), 32'h1);
        access(1, 1'b0, 32'h0000_0010, 32'h0, 3'b010);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                rst_n[k] = ($urandom_range(0, 299) != 0);
                for (int p = 0; p < 2; p++) begin
                    if (req[k][p] && exp_gnt(k, p)) begin
                        if ($urandom_range(0, 1) == 0) req[k][p] = 1'b0;
                        else rand_fields(k, p);
                    end else if (!req[k][p] && $urandom_range(0, 2) == 0) begin
                        req[k][p] = 1'b1;
                        rand_fields(k, p);
                    end
                end
            end
            step();
        end
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        idle_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
